// File: rtl/usr_sequencer_pkg.sv
// Shared types for the shift-register sequencer: opcodes, FSM states and
// the datapath mode encoding used between the sequencer and its core.
package usr_sequencer_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHR   = 3'b010,
    OP_SHL   = 3'b011,
    OP_ROTR  = 3'b100,
    OP_ROTL  = 3'b101,
    OP_CLEAR = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    CORE_HOLD,
    CORE_SHR,
    CORE_SHL,
    CORE_LOAD
  } core_mode_e;

  // Ops that consume the step counter, one 1-bit move per EXEC edge.
  function automatic logic is_step_op(input op_e op);
    return op inside {OP_SHR, OP_SHL, OP_ROTR, OP_ROTL};
  endfunction

endpackage

// File: rtl/usr_core.sv
// Register datapath: hold, shift right, shift left or parallel load,
// with independent serial inputs at each end and a global enable.
module usr_core
  import usr_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  core_mode_e       mode_i,
  input  logic             ser_l_i,
  input  logic             ser_r_i,
  input  logic [WIDTH-1:0] par_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    unique case (mode_i)
      CORE_SHR:  q_d = {ser_l_i, q_q[WIDTH-1:1]};
      CORE_SHL:  q_d = {q_q[WIDTH-2:0], ser_r_i};
      CORE_LOAD: q_d = par_i;
      default:   q_d = q_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/usr_sequencer.sv
// Command sequencer around usr_core: accepts one command in IDLE, runs it in
// EXEC (one step per edge, abortable), then pulses done for one DONE cycle.
module usr_sequencer
  import usr_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             core_en;
  core_mode_e       core_mode;
  logic [WIDTH-1:0] core_par;
  logic             ser_l, ser_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    data_d    = data_q;
    core_en   = 1'b0;
    core_mode = CORE_HOLD;
    core_par  = '0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          cnt_d  = cmd_cnt;
          fill_d = cmd_fill;
          data_d = cmd_data;
          if (op_d == OP_LOAD || op_d == OP_CLEAR ||
              (is_step_op(op_d) && cmd_cnt != '0)) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_EXEC: begin
        busy = 1'b1;
        if (abort) begin
          state_d = ST_DONE;
        end else begin
          core_en = 1'b1;
          unique case (op_q)
            OP_LOAD: begin
              core_mode = CORE_LOAD;
              core_par  = data_q;
            end
            OP_CLEAR:         core_mode = CORE_LOAD;
            OP_SHR, OP_ROTR:  core_mode = CORE_SHR;
            OP_SHL, OP_ROTL:  core_mode = CORE_SHL;
            default:          core_en   = 1'b0;
          endcase

          if (is_step_op(op_q)) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_d = ST_DONE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Rotates recirculate the outgoing bit; plain shifts take the latched fill.
  assign ser_l = (op_q == OP_ROTR) ? q[0]       : fill_q;
  assign ser_r = (op_q == OP_ROTL) ? q[WIDTH-1] : fill_q;

  usr_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .en_i    (core_en),
    .mode_i  (core_mode),
    .ser_l_i (ser_l),
    .ser_r_i (ser_r),
    .par_i   (core_par),
    .q_o     (q)
  );

endmodule

// File: tb/tb_usr_sequencer.sv
// Directed bench for usr_sequencer: stimulus pushes expected completions into
// a scoreboard that a negedge monitor pops on every done pulse.
module tb_usr_sequencer;
  import usr_sequencer_pkg::*;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'b000;
  logic [CW-1:0] cmd_cnt = '0;
  logic          cmd_fill = 1'b0;
  logic [W-1:0]  cmd_data = '0;
  logic          abort = 1'b0;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  usr_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_fill  (cmd_fill),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .q         (q),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    string        name;
    logic [W-1:0] q;
    int           busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts busy cycles and checks each completion against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          check("done has pending command", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.name, " q at done"}, q, e.q);
            check({e.name, " busy cycles"}, busy_cnt, e.busy);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input string name);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, " ready"}, cmd_ready, 1);
  endtask

  // Presents one command for a single accept edge, then scrambles cmd_*.
  task automatic send(input string name, input logic [2:0] op, input logic [CW-1:0] cnt,
                      input logic fill, input logic [W-1:0] data, input logic ab,
                      input logic push, input logic [W-1:0] eq, input int eb);
    exp_t e;
    wait_ready(name);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_fill  = fill;
    cmd_data  = data;
    abort     = ab;
    if (push) begin
      e.name = name;
      e.q    = eq;
      e.busy = eb;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    cmd_op    = 3'b110;
    cmd_cnt   = '1;
    cmd_fill  = ~fill;
    cmd_data  = ~data;
  endtask

  logic [W-1:0] rotl_exp [5];

  initial begin
    rotl_exp = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset q", q, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset ready", cmd_ready, 1);
    check("post-reset q", q, 0);

    // LOAD 1011: EXEC then DONE
    send("load1011", OP_LOAD, 4'd0, 1'b0, 4'b1011, 1'b0, 1'b1, 4'b1011, 2);
    check("load exec busy", busy, 1);
    check("load exec ready", cmd_ready, 0);
    check("load exec q", q, 0);
    @(posedge clk); #1;
    check("load q", q, 4'b1011);
    check("load done", done, 1);
    @(posedge clk); #1;
    check("load idle ready", cmd_ready, 1);
    check("load idle done", done, 0);

    // SHR cnt=2 fill=1 on 1011
    send("shr2", OP_SHR, 4'd2, 1'b1, 4'b0000, 1'b0, 1'b1, 4'b1110, 3);
    check("shr2 pre-step q", q, 4'b1011);
    @(posedge clk); #1;
    check("shr2 step1 q", q, 4'b1101);
    check("shr2 step1 done", done, 0);
    @(posedge clk); #1;
    check("shr2 step2 q", q, 4'b1110);
    check("shr2 step2 done", done, 1);

    // ROTL cnt=5 on 1001
    send("load1001", OP_LOAD, 4'd0, 1'b0, 4'b1001, 1'b0, 1'b1, 4'b1001, 2);
    send("rotl5", OP_ROTL, 4'd5, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0011, 6);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("rotl5 step%0d q", i + 1), q, rotl_exp[i]);
    end
    check("rotl5 done", done, 1);

    // LOAD with abort high on the accept edge must still run
    send("load0110 abort-at-accept", OP_LOAD, 4'd0, 1'b0, 4'b0110, 1'b1, 1'b1, 4'b0110, 2);

    // SHL cnt=3 fill=0, abort on the 2nd EXEC edge
    send("shl3 abort", OP_SHL, 4'd3, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1100, 3);
    @(posedge clk); #1;
    check("shl3 step1 q", q, 4'b1100);
    check("shl3 step1 done", done, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    check("shl3 aborted q", q, 4'b1100);
    check("shl3 aborted done", done, 1);
    check("shl3 aborted ready", cmd_ready, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("shl3 idle ready", cmd_ready, 1);
    check("shl3 idle q", q, 4'b1100);

    // SHR cnt=0 with cmd_valid held high: accepts only in IDLE
    send("load1111", OP_LOAD, 4'd0, 1'b0, 4'b1111, 1'b0, 1'b1, 4'b1111, 2);
    wait_ready("b2b");
    cmd_valid = 1'b1;
    cmd_op    = OP_SHR;
    cmd_cnt   = 4'd0;
    cmd_fill  = 1'b0;
    begin
      exp_t e;
      e.name = "shr0 first";  e.q = 4'b1111; e.busy = 1; sb.push_back(e);
      e.name = "shr0 second"; e.q = 4'b1111; e.busy = 1; sb.push_back(e);
    end
    @(posedge clk); #1;
    check("shr0 first done", done, 1);
    check("shr0 first q", q, 4'b1111);
    check("shr0 first ready", cmd_ready, 0);
    @(posedge clk); #1;
    check("shr0 gap ready", cmd_ready, 1);
    check("shr0 gap done", done, 0);
    @(posedge clk); #1;
    check("shr0 second done", done, 1);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("shr0 end ready", cmd_ready, 1);

    // Reset mid-EXEC of ROTR cnt=7
    send("load1010", OP_LOAD, 4'd0, 1'b0, 4'b1010, 1'b0, 1'b1, 4'b1010, 2);
    send("rotr7", OP_ROTR, 4'd7, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 0);
    @(posedge clk); #1;
    check("rotr7 step1 q", q, 4'b0101);
    @(posedge clk); #1;
    check("rotr7 step2 q", q, 4'b1010);
    #2 rst = 1'b1;
    #1;
    check("async reset q", q, 0);
    check("async reset busy", busy, 0);
    check("async reset done", done, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("after reset ready", cmd_ready, 1);
    check("after reset q", q, 0);
    check("after reset busy", busy, 0);

    check("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
